// File: rtl/rs232_baud_gen.sv
// RS232 bit-rate and receiver-oversampling enable generator with a runtime
// divisor that is shadowed and applied only at a bit boundary, on resync, or while idle.
module rs232_baud_gen #(
    parameter int unsigned DIV_WIDTH   = 20,
    parameter int unsigned DEFAULT_DIV = 10417,
    parameter int unsigned OVERSAMPLE  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 div_load,
    input  logic [DIV_WIDTH-1:0] div_in,
    input  logic                 resync,
    output logic                 clk_rs232_en,
    output logic                 clk_rs232_os_en,
    output logic [DIV_WIDTH-1:0] div_cur
);

    localparam int unsigned          OS_LOG2 = $clog2(OVERSAMPLE);
    localparam logic [DIV_WIDTH-1:0] OS_MIN  = DIV_WIDTH'(OVERSAMPLE);
    localparam logic [DIV_WIDTH-1:0] DEF_RAW = DIV_WIDTH'(DEFAULT_DIV);
    localparam logic [DIV_WIDTH-1:0] DEF_DIV = (DEF_RAW < OS_MIN) ? OS_MIN : DEF_RAW;

    logic [DIV_WIDTH-1:0] r_div_cur;
    logic [DIV_WIDTH-1:0] r_pend;
    logic                 r_pend_v;
    logic [DIV_WIDTH-1:0] r_cnt;
    logic [OS_LOG2-1:0]   r_slot;
    logic                 r_os_en;
    logic                 r_bit_en;

    logic [DIV_WIDTH-1:0] w_base;
    logic [OS_LOG2-1:0]   w_rem;
    logic [DIV_WIDTH-1:0] w_slot_len;
    logic [DIV_WIDTH-1:0] w_div_in_clamped;
    logic                 w_slot_end;
    logic                 w_last_slot;
    logic                 w_os_tick;
    logic                 w_bit_tick;
    logic                 w_xfer;

    // Slot i gets one extra cycle while i < rem so the slots sum exactly to D.
    always_comb begin
        w_base           = r_div_cur >> OS_LOG2;
        w_rem            = r_div_cur[OS_LOG2-1:0];
        w_slot_len       = w_base + DIV_WIDTH'(r_slot < w_rem);
        w_div_in_clamped = (div_in < OS_MIN) ? OS_MIN : div_in;
        // >= rather than == so a divisor shrunk while idle cannot strand cnt past the slot end
        w_slot_end       = (r_cnt >= (w_slot_len - DIV_WIDTH'(1)));
        w_last_slot      = (r_slot == '1);
        w_os_tick        = en && !resync && w_slot_end;
        w_bit_tick       = w_os_tick && w_last_slot;
        w_xfer           = r_pend_v && (resync || !en || w_bit_tick);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_div_cur <= DEF_DIV;
            r_pend    <= '0;
            r_pend_v  <= 1'b0;
            r_cnt     <= '0;
            r_slot    <= '0;
            r_os_en   <= 1'b0;
            r_bit_en  <= 1'b0;
        end else begin
            r_os_en  <= w_os_tick;
            r_bit_en <= w_bit_tick;

            if (resync) begin
                r_cnt  <= '0;
                r_slot <= '0;
            end else if (en) begin
                if (w_slot_end) begin
                    r_cnt  <= '0;
                    r_slot <= r_slot + OS_LOG2'(1);
                end else begin
                    r_cnt <= r_cnt + DIV_WIDTH'(1);
                end
            end

            if (w_xfer) begin
                r_div_cur <= r_pend;
            end

            // A load coinciding with a transfer becomes the next pending value.
            if (div_load) begin
                r_pend   <= w_div_in_clamped;
                r_pend_v <= 1'b1;
            end else if (w_xfer) begin
                r_pend_v <= 1'b0;
            end
        end
    end

    assign clk_rs232_en    = r_bit_en;
    assign clk_rs232_os_en = r_os_en;
    assign div_cur         = r_div_cur;

endmodule

// File: tb/tb_rs232_baud_gen.sv
// Directed bench for rs232_baud_gen: table of divisor settings plus hand-built
// sequences for reload, resync, enable gating and mid-period reset.
module tb_rs232_baud_gen;

    logic        clk;
    logic        rst;
    logic        en;
    logic        div_load;
    logic [19:0] div_in;
    logic        resync;
    logic        clk_rs232_en;
    logic        clk_rs232_os_en;
    logic [19:0] div_cur;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    typedef struct {
        logic [19:0] div_in;
        int unsigned exp_div;
        int unsigned exp_first_os;
        int unsigned exp_period;
    } vec_t;

    vec_t vecs[10];

    rs232_baud_gen #(
        .DIV_WIDTH  (20),
        .DEFAULT_DIV(10417),
        .OVERSAMPLE (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .div_load       (div_load),
        .div_in         (div_in),
        .resync         (resync),
        .clk_rs232_en   (clk_rs232_en),
        .clk_rs232_os_en(clk_rs232_os_en),
        .div_cur        (div_cur)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Steps until the requested pulse appears (bounded); edges includes the hit edge.
    task automatic run_until(input bit want_bit, input int unsigned limit,
                             output int unsigned edges, output int unsigned os_seen);
        bit hit;
        hit     = 1'b0;
        edges   = 0;
        os_seen = 0;
        while (!hit && edges <= limit) begin
            tick();
            edges++;
            if (clk_rs232_os_en === 1'b1) os_seen++;
            hit = want_bit ? (clk_rs232_en === 1'b1) : (clk_rs232_os_en === 1'b1);
        end
    endtask

    task automatic program_div(input logic [19:0] d);
        en       = 1'b0;
        div_in   = d;
        div_load = 1'b1;
        tick();
        div_load = 1'b0;
        tick();
        resync = 1'b1;
        tick();
        resync = 1'b0;
        en     = 1'b1;
    endtask

    initial begin
        int unsigned e, o, e2, o2, pulses;

        vecs[0] = '{20'd5,    16,   1,  16};
        vecs[1] = '{20'd0,    16,   1,  16};
        vecs[2] = '{20'd15,   16,   1,  16};
        vecs[3] = '{20'd16,   16,   1,  16};
        vecs[4] = '{20'd17,   17,   2,  17};
        vecs[5] = '{20'd31,   31,   2,  31};
        vecs[6] = '{20'd32,   32,   2,  32};
        vecs[7] = '{20'd100,  100,  7,  100};
        vecs[8] = '{20'd868,  868,  55, 868};
        vecs[9] = '{20'd1000, 1000, 63, 1000};

        rst = 1'b0; en = 1'b0; div_load = 1'b0; div_in = '0; resync = 1'b0;
        repeat (3) tick();
        chk("rst_bit_en", 32'(clk_rs232_en), 0);
        chk("rst_os_en", 32'(clk_rs232_os_en), 0);
        chk("rst_div_cur", 32'(div_cur), 10417);

        // Default rate from reset release
        rst = 1'b1; en = 1'b1;
        run_until(1'b0, 1000, e, o);  chk("def_first_os", e, 652);
        run_until(1'b0, 1000, e, o);  chk("def_second_os", e, 651);
        run_until(1'b1, 11000, e, o); chk("def_bit_rest", e, 9114);
        chk("def_os_rest", o, 14);
        chk("def_bit_with_os", 32'(clk_rs232_os_en), 1);

        // Reload at cycle 3000 of a period
        repeat (2999) tick();
        div_load = 1'b1; div_in = 20'd868;
        tick();
        div_load = 1'b0;
        chk("reload_not_yet", 32'(div_cur), 10417);
        run_until(1'b1, 11000, e, o); chk("reload_old_end", e, 7417);
        chk("reload_div_cur", 32'(div_cur), 868);
        for (int i = 0; i < 4; i++) begin
            run_until(1'b0, 100, e, o);
            chk($sformatf("reload_long_slot%0d", i), e, 55);
        end
        run_until(1'b1, 1000, e, o);  chk("reload_short_slots", e, 648);
        chk("reload_short_os", o, 12);
        run_until(1'b1, 1000, e, o);  chk("reload_period", e, 868);
        chk("reload_os_per_bit", o, 16);

        // Divisor table: clamp, minimum and remainder distribution
        for (int i = 0; i < 10; i++) begin
            program_div(vecs[i].div_in);
            chk($sformatf("tbl%0d_div_cur", i), 32'(div_cur), vecs[i].exp_div);
            run_until(1'b0, vecs[i].exp_period + 4, e, o);
            chk($sformatf("tbl%0d_first_os", i), e, vecs[i].exp_first_os);
            run_until(1'b1, 2000, e2, o2);
            chk($sformatf("tbl%0d_period", i), e + e2, vecs[i].exp_period);
            chk($sformatf("tbl%0d_os_per_bit", i), o + o2, 16);
            tick();
            chk($sformatf("tbl%0d_bit_width", i), 32'(clk_rs232_en), 0);
        end

        // Resync lands on a due os tick at D=16
        program_div(20'd5);
        repeat (5) tick();
        resync = 1'b1;
        tick();
        resync = 1'b0;
        chk("rs16_os_suppressed", 32'(clk_rs232_os_en), 0);
        chk("rs16_bit_suppressed", 32'(clk_rs232_en), 0);
        run_until(1'b0, 20, e, o);    chk("rs16_next_os", e, 1);
        run_until(1'b1, 40, e, o);    chk("rs16_next_bit", e, 15);

        // Last load wins; load coinciding with a transfer is kept
        program_div(20'd16);
        repeat (9) tick();
        div_load = 1'b1; div_in = 20'd24;
        tick();
        div_in = 20'd20;
        tick();
        div_load = 1'b0;
        repeat (4) tick();
        div_load = 1'b1; div_in = 20'd32;
        tick();
        div_load = 1'b0;
        chk("xfer_bit_edge", 32'(clk_rs232_en), 1);
        chk("xfer_last_wins", 32'(div_cur), 20);
        run_until(1'b1, 100, e, o);   chk("xfer_period20", e, 20);
        chk("xfer_kept", 32'(div_cur), 32);
        run_until(1'b1, 100, e, o);   chk("xfer_period32", e, 32);

        // Resync 5000 cycles into a default period
        program_div(20'd10417);
        repeat (4999) tick();
        resync = 1'b1;
        tick();
        resync = 1'b0;
        chk("rs_no_os", 32'(clk_rs232_os_en), 0);
        chk("rs_no_bit", 32'(clk_rs232_en), 0);
        run_until(1'b0, 1000, e, o);  chk("rs_next_os", e, 652);
        run_until(1'b1, 11000, e, o); chk("rs_next_bit", e, 10417 - 652);
        chk("rs_os_rest", o, 15);

        // Resync applies a pending divisor
        repeat (97) tick();
        div_load = 1'b1; div_in = 20'd868;
        tick();
        div_load = 1'b0;
        repeat (2) tick();
        resync = 1'b1;
        tick();
        resync = 1'b0;
        chk("rs_pend_div_cur", 32'(div_cur), 868);
        run_until(1'b1, 2000, e, o);  chk("rs_pend_period", e, 868);

        // Enable dropped for 100 cycles mid-slot
        program_div(20'd10417);
        repeat (1000) tick();
        en = 1'b0;
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (clk_rs232_os_en !== 1'b0 || clk_rs232_en !== 1'b0) pulses++;
        end
        chk("gate_no_pulses", pulses, 0);
        en = 1'b1;
        run_until(1'b0, 1000, e, o);  chk("gate_next_os", e, 303);
        run_until(1'b1, 11000, e, o); chk("gate_bit_rest", e, 9114);
        chk("gate_os_rest", o, 14);

        // Reset two cycles before a due bit tick with a pending divisor
        program_div(20'd10417);
        repeat (9999) tick();
        div_load = 1'b1; div_in = 20'd868;
        tick();
        div_load = 1'b0;
        repeat (414) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mrst_no_os", 32'(clk_rs232_os_en), 0);
        chk("mrst_no_bit", 32'(clk_rs232_en), 0);
        chk("mrst_div_cur", 32'(div_cur), 10417);
        run_until(1'b1, 11000, e, o); chk("mrst_next_bit", e, 10417);
        chk("mrst_pend_discarded", 32'(div_cur), 10417);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
